// File: rtl/jk_counter_reg.sv
// -----------------------------------------------------------------------------
// jk_counter_reg
//   N-bit multi-mode register: per-bit JK flip-flop bank, up/down counter with
//   optional saturation, and serial left shifter. Flags wrap-around, saturation
//   hits and shifted-out ones with a registered one-cycle OVF pulse.
//
// Parameters
//   WIDTH        register width in bits (>= 2)
//   RESET_VALUE  value loaded into Q while RESET_N is low
//   SATURATE     0: counting wraps, 1: counting clamps at the end value
//
// Ports
//   CLK      in   1      rising-edge clock
//   RESET_N  in   1      asynchronous active-low reset
//   EN       in   1      synchronous enable (0 = hold, OVF low)
//   MODE     in   2      00 JK, 01 count up, 10 count down, 11 shift left
//   J, K     in   WIDTH  per-bit JK controls (JK mode only)
//   SIN      in   1      serial input into bit 0 (shift mode only)
//   Q        out  WIDTH  register contents
//   TC       out  1      terminal count, combinational from Q and MODE
//   OVF      out  1      registered wrap / saturation / shift-out pulse
// -----------------------------------------------------------------------------
module jk_counter_reg #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter bit                 SATURATE    = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_min;

  assign at_max = (q_q == ALL_ONES);
  assign at_min = (q_q == ZERO);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the case/if tree leaves it unassigned and infers a latch.
    q_d   = q_q;
    ovf_d = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_JK: begin
          // Per-bit JK: set where J only, clear where K only, toggle where both.
          q_d = (J & ~K) | (~J & ~K & q_q) | (J & K & ~q_q);
        end
        MODE_UP: begin
          if (at_max) begin
            q_d   = SATURATE ? ALL_ONES : ZERO;
            ovf_d = 1'b1;
          end else begin
            q_d = q_q + ONE;
          end
        end
        MODE_DOWN: begin
          if (at_min) begin
            q_d   = SATURATE ? ZERO : ALL_ONES;
            ovf_d = 1'b1;
          end else begin
            q_d = q_q - ONE;
          end
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], SIN};
          ovf_d = q_q[WIDTH-1];
        end
        default: begin
          q_d   = q_q;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_q   <= RESET_VALUE;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  // TC deliberately ignores EN: it reports where Q sits relative to the
  // current counting direction.
  always_comb begin
    TC = 1'b0;
    case (MODE)
      MODE_UP:   TC = at_max;
      MODE_DOWN: TC = at_min;
      default:   TC = 1'b0;
    endcase
  end

  assign Q   = q_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// -----------------------------------------------------------------------------
// tb_jk_counter_reg
//   Two instances share one stimulus: a wrapping counter (SATURATE=0) and a
//   saturating one (SATURATE=1), both WIDTH=4, RESET_VALUE=4'h5. A directed
//   vector table, hand-written reset sequences and a random phase are compared
//   against a behavioural model of the register.
// -----------------------------------------------------------------------------
module tb_jk_counter_reg;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'h5;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j, k;
  logic         sin;
  logic [W-1:0] q_w, q_s;
  logic         tc_w, tc_s, ovf_w, ovf_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state for each instance.
  logic [3:0] mq_w, mq_s;
  logic       movf_w, movf_s;

  jk_counter_reg #(.WIDTH(W), .RESET_VALUE(RV), .SATURATE(1'b0)) dut_w (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .MODE(mode), .J(j), .K(k),
    .SIN(sin), .Q(q_w), .TC(tc_w), .OVF(ovf_w)
  );

  jk_counter_reg #(.WIDTH(W), .RESET_VALUE(RV), .SATURATE(1'b1)) dut_s (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .MODE(mode), .J(j), .K(k),
    .SIN(sin), .Q(q_s), .TC(tc_s), .OVF(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural next-state rule, written from the mode descriptions.
  task automatic model_next(input logic [3:0] q, input logic e, input logic [1:0] m,
                            input logic [3:0] jj, input logic [3:0] kk, input logic s,
                            input bit sat, output logic [3:0] nq, output logic novf);
    int v;
    v    = int'(q);
    nq   = q;
    novf = 1'b0;
    if (e) begin
      case (m)
        2'd0: for (int i = 0; i < 4; i++) begin
          if (jj[i] && kk[i]) nq[i] = ~q[i];
          else if (jj[i])     nq[i] = 1'b1;
          else if (kk[i])     nq[i] = 1'b0;
        end
        2'd1: if (v == 15) begin novf = 1'b1; nq = sat ? 4'd15 : 4'd0; end
              else nq = 4'(v + 1);
        2'd2: if (v == 0) begin novf = 1'b1; nq = sat ? 4'd0 : 4'd15; end
              else nq = 4'(v - 1);
        default: begin
          nq   = 4'((v * 2 + int'(s)) % 16);
          novf = (v >= 8);
        end
      endcase
    end
  endtask

  function automatic logic model_tc(input logic [3:0] q, input logic [1:0] m);
    if (m == 2'd1) return (q == 4'd15);
    if (m == 2'd2) return (q == 4'd0);
    return 1'b0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, " q_w"},   q_w,   mq_w);
    check({tag, " ovf_w"}, ovf_w, movf_w);
    check({tag, " tc_w"},  tc_w,  model_tc(mq_w, mode));
    check({tag, " q_s"},   q_s,   mq_s);
    check({tag, " ovf_s"}, ovf_s, movf_s);
    check({tag, " tc_s"},  tc_s,  model_tc(mq_s, mode));
  endtask

  // One clock edge: advance the model from pre-edge values, then sample 1 ns on.
  task automatic step();
    logic [3:0] nw, ns;
    logic       ow, os;
    @(posedge clk);
    model_next(mq_w, en, mode, j, k, sin, 1'b0, nw, ow);
    model_next(mq_s, en, mode, j, k, sin, 1'b1, ns, os);
    mq_w = nw; movf_w = ow;
    mq_s = ns; movf_s = os;
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] jj,
                       input logic [3:0] kk, input logic s);
    en = e; mode = m; j = jj; k = kk; sin = s;
  endtask

  task automatic model_reset();
    mq_w = RV; mq_s = RV; movf_w = 1'b0; movf_s = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] j, k;
    logic       sin;
    logic [3:0] q_w;  logic ovf_w; logic tc_w;
    logic [3:0] q_s;  logic ovf_s; logic tc_s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // en mode j k sin | q_w ovf_w tc_w | q_s ovf_s tc_s
    vecs.push_back('{1, 2'd0, 4'hE, 4'h1, 0, 4'hE, 0, 0, 4'hE, 0, 0}); // load E
    vecs.push_back('{1, 2'd0, 4'hA, 4'h5, 0, 4'hA, 0, 0, 4'hA, 0, 0}); // load 1010
    vecs.push_back('{1, 2'd0, 4'hC, 4'h6, 0, 4'hC, 0, 0, 4'hC, 0, 0}); // JK mix -> 1100
    vecs.push_back('{1, 2'd0, 4'hE, 4'h1, 0, 4'hE, 0, 0, 4'hE, 0, 0}); // load E
    vecs.push_back('{1, 2'd1, 4'hF, 4'hF, 1, 4'hF, 0, 1, 4'hF, 0, 1}); // up, J/K/SIN ignored
    vecs.push_back('{1, 2'd1, 4'h0, 4'h0, 0, 4'h0, 1, 0, 4'hF, 1, 1}); // wrap / clamp
    vecs.push_back('{1, 2'd1, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'hF, 1, 1}); // clamp repeats
    vecs.push_back('{1, 2'd0, 4'h1, 4'hE, 0, 4'h1, 0, 0, 4'h1, 0, 0}); // load 1
    vecs.push_back('{1, 2'd2, 4'h0, 4'h0, 0, 4'h0, 0, 1, 4'h0, 0, 1}); // down to 0
    vecs.push_back('{1, 2'd2, 4'h0, 4'h0, 0, 4'hF, 1, 0, 4'h0, 1, 1}); // wrap / clamp
    vecs.push_back('{0, 2'd2, 4'hF, 4'hF, 1, 4'hF, 0, 0, 4'h0, 0, 1}); // EN=0 hold
    vecs.push_back('{1, 2'd0, 4'h9, 4'h6, 0, 4'h9, 0, 0, 4'h9, 0, 0}); // load 1001
    vecs.push_back('{1, 2'd3, 4'h0, 4'hF, 1, 4'h3, 1, 0, 4'h3, 1, 0}); // shift out 1
    vecs.push_back('{1, 2'd3, 4'hF, 4'h0, 1, 4'h7, 0, 0, 4'h7, 0, 0}); // shift out 0
    vecs.push_back('{0, 2'd3, 4'h0, 4'h0, 0, 4'h7, 0, 0, 4'h7, 0, 0}); // EN=0 in shift
    vecs.push_back('{1, 2'd0, 4'hF, 4'hF, 0, 4'h8, 0, 0, 4'h8, 0, 0}); // toggle all
  end

  initial begin
    drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset immediate q_w",   q_w,   RV);
    check("reset immediate ovf_w", ovf_w, 1'b0);
    check("reset immediate q_s",   q_s,   RV);
    check("reset immediate ovf_s", ovf_s, 1'b0);
    model_reset();
    // Reset holds across edges even with counting requested.
    drive(1'b1, 2'd1, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset hold q_w",   q_w,   RV);
      check("reset hold ovf_w", ovf_w, 1'b0);
      check("reset hold q_s",   q_s,   RV);
    end
    #3 rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    step();
    check_model("post reset");

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].sin);
      step();
      check($sformatf("vec%0d q_w", i),   q_w,   vecs[i].q_w);
      check($sformatf("vec%0d ovf_w", i), ovf_w, vecs[i].ovf_w);
      check($sformatf("vec%0d tc_w", i),  tc_w,  vecs[i].tc_w);
      check($sformatf("vec%0d q_s", i),   q_s,   vecs[i].q_s);
      check($sformatf("vec%0d ovf_s", i), ovf_s, vecs[i].ovf_s);
      check($sformatf("vec%0d tc_s", i),  tc_s,  vecs[i].tc_s);
    end

    // Reset mid-count: load 6, count to 7, drop reset between edges.
    drive(1'b1, 2'd0, 4'h6, 4'h9, 1'b0);
    step();
    drive(1'b1, 2'd1, 4'h0, 4'h0, 1'b0);
    step();
    check("count to 7 q_w", q_w, 4'h7);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid reset q_w",   q_w,   RV);
    check("mid reset ovf_w", ovf_w, 1'b0);
    check("mid reset q_s",   q_s,   RV);
    @(posedge clk); #3 rst_n = 1'b1;
    step();
    check("first edge after release q_w", q_w, RV + 4'h1);
    check("first edge after release q_s", q_s, RV + 4'h1);

    // Random phase against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom), 1'($urandom));
      // Occasionally park near the end values to hit wrap and clamp often.
      if ($urandom_range(0, 9) == 0) drive(1'b1, 2'd0, 4'hF, 4'h0, 1'b0);
      if ($urandom_range(0, 9) == 0) drive(1'b1, 2'd0, 4'h0, 4'hF, 1'b0);
      #1; // TC must follow MODE combinationally before the next edge
      check("rand tc_w pre-edge", tc_w, model_tc(mq_w, mode));
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_counter_reg.md
# jk_counter_reg

Parametrised multi-mode register: an N-bit JK register bank that also counts up or down, shifts serially, and flags wrap-around. It replaces hand-instantiated single-bit JK flip-flop chains in the lab datapaths and serves as the standard counter/shift primitive for later assignments.

## Interface
- WIDTH, 4: register width in bits, at least 2.
- RESET_VALUE, 0: value Q takes on reset; WIDTH bits.
- SATURATE, 0: 0 means counting wraps; 1 means counting clamps at the end value.

Ports:
- CLK  input  1  clock; all state changes occur on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- EN  input  1  synchronous enable; 0 means hold in every mode.
- MODE  input  2  operating mode: 00 is JK, 01 is count up, 10 is count down, 11 is shift left.
- J  input  WIDTH  per-bit J inputs, used in JK mode only.
- K  input  WIDTH  per-bit K inputs, used in JK mode only.
- SIN  input  1  serial input, shifted into bit 0 in shift mode.
- Q  output  WIDTH  register contents.
- TC  output  1  terminal count, combinational from Q and MODE.
- OVF  output  1  registered one-cycle pulse marking a wrap, a saturation hit, or a shifted-out 1.

## Operation
- Reset (RESET_N=0, regardless of CLK): Q=RESET_VALUE and OVF=0. Both are held while RESET_N is low. Reset takes priority over every other input.
- EN=0: Q holds and OVF=0 on the next edge, for any MODE.
- MODE 00, JK, applied independently to each bit i:
  - J=0, K=0: hold.
  - J=1, K=0: set the bit.
  - J=0, K=1: clear the bit.
  - J=1, K=1: toggle the bit.
  - OVF=0 in this mode.
- MODE 01, count up:
  - Q below all-ones: Q becomes Q+1.
  - Q at all-ones with SATURATE=0: Q wraps to 0 and OVF=1.
  - Q at all-ones with SATURATE=1: Q stays at all-ones and OVF=1.
- MODE 10, count down:
  - Q above 0: Q becomes Q-1.
  - Q at 0 with SATURATE=0: Q wraps to all-ones and OVF=1.
  - Q at 0 with SATURATE=1: Q stays at 0 and OVF=1.
- MODE 11, shift left:
  - Q becomes {Q[WIDTH-2:0], SIN}.
  - OVF equals the old Q[WIDTH-1], so it pulses whenever a 1 is shifted out.
- All counter arithmetic is unsigned modulo 2^WIDTH with no sign handling.
- TC is combinational:
  - MODE 01: TC=1 iff Q is all-ones.
  - MODE 10: TC=1 iff Q=0.
  - MODE 00 or 11: TC=0.
  - TC does not depend on EN.
- J, K and SIN are ignored outside their own modes.
- A MODE change takes effect at the next edge, with no pipeline and no flush.

## Timing
- Q and OVF are registered with 1-cycle latency from the inputs sampled at the edge.
- OVF is high for exactly one cycle per event. It stays high on consecutive cycles only if the event repeats, for example saturated counting at the end value.
- Asserting RESET_N mid-count clears Q and OVF asynchronously, without waiting for an edge.
- Deasserting RESET_N is synchronous in effect: the first state change is on the first rising CLK edge after release.
- An edge coinciding with reset release is not guaranteed to update state. Benches keep RESET_N changes at least 1 ns away from CLK edges.
- TC is a combinational path from Q and MODE and settles within the same cycle.

## Test plan
- Reset: WIDTH=4, RESET_VALUE=4'h5; pull RESET_N low between edges. Q=4'h5 and OVF=0 immediately, before any CLK edge, and both hold over 3 edges.
- JK mode: Q=4'b1010, J=4'b1100, K=4'b0110, EN=1, one edge.
  - Bit 3 sets and bit 2 toggles to 1.
  - Bit 1 clears and bit 0 holds at 0.
  - Result Q=4'b1100, OVF=0.
- Up wrap: SATURATE=0, Q=4'hE, MODE=01.
  - Edge 1: Q=4'hF, TC=1.
  - Edge 2: Q=4'h0, OVF=1.
  - Edge 3: Q=4'h1, OVF=0.
- Down saturate: SATURATE=1, Q=4'h1, MODE=10.
  - Edge 1: Q=4'h0, TC=1.
  - Edge 2: Q=4'h0, OVF=1.
  - Drop EN: Q=4'h0, OVF=0.
- Shift: Q=4'b1001, MODE=11, SIN=1.
  - Edge 1: Q=4'b0011, OVF=1.
  - Edge 2: Q=4'b0111, OVF=0.
- Reset mid-operation: counting up with EN=1, drop RESET_N at Q=4'h7.
  - Q=RESET_VALUE and OVF=0 at once.
  - After release, the first edge gives RESET_VALUE+1.
